// File: rtl/flash_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped SPI flash word cache.
package flash_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEF_LINES = 64;
    localparam int DEF_AW    = 18;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int aw, input int lines);
        return aw - $clog2(lines);
    endfunction

endpackage

// File: rtl/flash_cache_ram.sv
// Valid/tag/data line storage: asynchronous read, one synchronous write port,
// and a single-cycle clear of every valid bit.
module flash_cache_ram
    import flash_cache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int TAG_W = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [index_w(LINES)-1:0]   raddr,
    output logic                        rvalid,
    output logic [TAG_W-1:0]            rtag,
    output logic [31:0]                 rdata,
    input  logic                        we,
    input  logic [index_w(LINES)-1:0]   waddr,
    input  logic                        wvalid,
    input  logic [TAG_W-1:0]            wtag,
    input  logic [31:0]                 wdata
);

    logic [LINES-1:0]            valid;
    logic [LINES-1:0][TAG_W-1:0] tags;
    logic [LINES-1:0][31:0]      data;

    assign rvalid = valid[raddr];
    assign rtag   = tags[raddr];
    assign rdata  = data[raddr];

    // Clear takes priority so a flush landing on a fill leaves the line invalid.
    always_ff @(posedge clk) begin
        if (reset || clear)
            valid <= '0;
        else if (we)
            valid[waddr] <= wvalid;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[waddr] <= wtag;
            data[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mapped_spi_flash_cache.sv
// Direct-mapped read-only word cache in front of the memory-mapped SPI flash
// reader: one-cycle hits, misses fetch one word from flash and fill the line.
module mapped_spi_flash_cache
    import flash_cache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_rstrb,
    input  logic [AW-1:0] mem_word_address,
    output logic [31:0]   mem_rdata,
    output logic          mem_rbusy,
    input  logic          flush,
    output logic          flash_rstrb,
    output logic [AW-1:0] flash_word_address,
    input  logic [31:0]   flash_rdata,
    input  logic          flash_rbusy
);

    localparam int IW = index_w(LINES);
    localparam int TW = tag_w(AW, LINES);

    state_t        state, state_nxt;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic [31:0]   line_data;
    logic          hit;
    logic          fill;
    logic          fill_ok;

    assign hit       = line_valid && (line_tag == mem_word_address[AW-1:IW]);
    assign fill      = (state == WAIT) && !flash_rbusy;
    assign mem_rbusy = (state != IDLE);

    flash_cache_ram #(
        .LINES (LINES),
        .TAG_W (TW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .raddr  (mem_word_address[IW-1:0]),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data),
        .we     (fill),
        .waddr  (flash_word_address[IW-1:0]),
        .wvalid (fill_ok),
        .wtag   (flash_word_address[AW-1:IW]),
        .wdata  (flash_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_rstrb && !hit) state_nxt = ISSUE;
            ISSUE:   if (flash_rstrb)       state_nxt = WAIT;
            WAIT:    if (!flash_rbusy)      state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            flash_rstrb        <= 1'b0;
            flash_word_address <= '0;
            mem_rdata          <= '0;
            fill_ok            <= 1'b0;
        end else begin
            state <= state_nxt;
            // Strobe only once the reader is idle, so a transfer abandoned by
            // reset drains before the next one is issued.
            flash_rstrb <= (state_nxt == ISSUE) && !flash_rbusy;
            if ((state == IDLE) && mem_rstrb) begin
                if (hit) begin
                    mem_rdata <= line_data;
                end else begin
                    flash_word_address <= mem_word_address;
                    fill_ok            <= 1'b1;
                end
            end
            // A flush while the miss is in flight must not validate the late fill.
            if ((state != IDLE) && flush)
                fill_ok <= 1'b0;
            if (fill)
                mem_rdata <= flash_rdata;
        end
    end

endmodule

// File: tb/tb_mapped_spi_flash_cache.sv
// Directed and random checks of the flash word cache against a flash reader
// model with adjustable latency and a reference direct-mapped hit model.
module tb_mapped_spi_flash_cache;

    localparam int LINES = 64;
    localparam int AW    = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_rstrb = 1'b0;
    logic [AW-1:0] mem_word_address = '0;
    logic          flush = 1'b0;
    logic [31:0]   mem_rdata;
    logic          mem_rbusy;
    logic          flash_rstrb;
    logic [AW-1:0] flash_word_address;
    logic [31:0]   flash_rdata = '0;
    logic          flash_rbusy = 1'b0;

    int            n_chk = 0;
    int            n_fail = 0;
    int            lat = 3;
    int            cnt = 0;
    int            n_strb = 0;
    int            overlap = 0;
    logic [AW-1:0] last_addr = '0;

    always #5 clk = ~clk;

    mapped_spi_flash_cache #(
        .LINES (LINES),
        .AW    (AW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_rstrb          (mem_rstrb),
        .mem_word_address   (mem_word_address),
        .mem_rdata          (mem_rdata),
        .mem_rbusy          (mem_rbusy),
        .flush              (flush),
        .flash_rstrb        (flash_rstrb),
        .flash_word_address (flash_word_address),
        .flash_rdata        (flash_rdata),
        .flash_rbusy        (flash_rbusy)
    );

    function automatic logic [31:0] mw(input logic [AW-1:0] a);
        return (a == 18'h00010) ? 32'hDEADBEEF : {14'h1A5C, a};
    endfunction

    // Flash reader: busy rises on the falling edge inside the strobe cycle,
    // stays high for lat sampled cycles, then presents the word.
    always @(negedge clk) begin
        if (flash_rstrb) begin
            if (flash_rbusy) overlap++;
            n_strb++;
            last_addr   = flash_word_address;
            flash_rbusy = 1'b1;
            cnt         = lat;
        end else if (flash_rbusy) begin
            cnt--;
            if (cnt <= 0) begin
                flash_rbusy = 1'b0;
                flash_rdata = mw(last_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_read(input logic [AW-1:0] a);
        @(negedge clk);
        mem_rstrb        = 1'b1;
        mem_word_address = a;
        @(negedge clk);
        mem_rstrb = 1'b0;
    endtask

    task automatic finish_read(output logic [31:0] d, output int cyc);
        cyc = 1;
        while (mem_rbusy && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (mem_rbusy) chk("read_timeout", 32'd1, 32'd0);
        d = mem_rdata;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output int cyc);
        start_read(a);
        finish_read(d, cyc);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   d;
        int            cyc;
        int            s0;
        logic [AW-1:0] a;
        logic [5:0]    idx;
        logic          ref_hit;
        logic [63:0]   ref_v;
        logic [11:0]   ref_tag [64];
        int            errs, dut_hits, ref_hits;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_rbusy", 32'(mem_rbusy), 32'd0);
        chk("rst_fstrb", 32'(flash_rstrb), 32'd0);
        chk("rst_faddr", 32'(flash_word_address), 32'd0);

        // cold miss then hit
        s0 = n_strb;
        do_read(18'h00010, d, cyc);
        chk("cold_data", d, 32'hDEADBEEF);
        chk("cold_strobes", 32'(n_strb - s0), 32'd1);
        chk("cold_faddr", 32'(last_addr), 32'h10);
        chk("cold_latency", 32'(cyc), 32'(lat + 2));
        s0 = n_strb;
        do_read(18'h00010, d, cyc);
        chk("hit_data", d, 32'hDEADBEEF);
        chk("hit_latency", 32'(cyc), 32'd1);
        chk("hit_strobes", 32'(n_strb - s0), 32'd0);

        // conflict eviction on index 5
        s0 = n_strb;
        do_read(18'h00005, d, cyc);
        chk("evict_a", d, mw(18'h00005));
        do_read(18'h00045, d, cyc);
        chk("evict_b", d, mw(18'h00045));
        do_read(18'h00005, d, cyc);
        chk("evict_a2", d, mw(18'h00005));
        chk("evict_strobes", 32'(n_strb - s0), 32'd3);

        // strobe during WAIT is ignored
        lat = 6;
        s0  = n_strb;
        start_read(18'h00200);
        @(negedge clk);
        mem_rstrb        = 1'b1;
        mem_word_address = 18'h00007;
        @(negedge clk);
        mem_rstrb = 1'b0;
        chk("ign_faddr_hold", 32'(flash_word_address), 32'h200);
        finish_read(d, cyc);
        chk("ign_data", d, mw(18'h00200));
        chk("ign_strobes", 32'(n_strb - s0), 32'd1);
        lat = 3;
        s0  = n_strb;
        do_read(18'h00007, d, cyc);
        chk("ign_not_filled", 32'(n_strb - s0), 32'd1);
        chk("ign_data2", d, mw(18'h00007));
        s0 = n_strb;
        do_read(18'h00200, d, cyc);
        chk("ign_line_kept", 32'(n_strb - s0), 32'd0);
        chk("ign_line_data", d, mw(18'h00200));

        // flush during an outstanding miss
        s0 = n_strb;
        start_read(18'h00100);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        finish_read(d, cyc);
        chk("flush_miss_data", d, mw(18'h00100));
        do_read(18'h00100, d, cyc);
        chk("flush_refetch", 32'(n_strb - s0), 32'd2);
        s0 = n_strb;
        do_read(18'h00010, d, cyc);
        chk("flush_clears_all", 32'(n_strb - s0), 32'd1);
        do_read(18'h00100, d, cyc);
        chk("flush_other_hit", d, mw(18'h00100));

        // flush coinciding with a hit still returns the hit
        s0 = n_strb;
        @(negedge clk);
        mem_rstrb        = 1'b1;
        mem_word_address = 18'h00010;
        flush            = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        flush     = 1'b0;
        chk("flush_hit_data", mem_rdata, 32'hDEADBEEF);
        chk("flush_hit_rbusy", 32'(mem_rbusy), 32'd0);
        chk("flush_hit_nostrb", 32'(n_strb - s0), 32'd0);
        do_read(18'h00010, d, cyc);
        chk("flush_hit_inval", 32'(n_strb - s0), 32'd1);

        // reset mid-miss: abandoned transfer must drain before the next strobe
        lat = 25;
        s0  = n_strb;
        start_read(18'h00300);
        repeat (2) @(negedge clk);
        pulse_reset();
        chk("rmid_rbusy", 32'(mem_rbusy), 32'd0);
        chk("rmid_rdata", mem_rdata, 32'h0);
        chk("rmid_fbusy_held", 32'(flash_rbusy), 32'd1);
        lat = 3;
        do_read(18'h00002, d, cyc);
        chk("rmid_data", d, mw(18'h00002));
        chk("rmid_overlap", 32'(overlap), 32'd0);
        chk("rmid_strobes", 32'(n_strb - s0), 32'd2);
        chk("rmid_waited", 32'(cyc > 15), 32'd1);
        s0 = n_strb;
        do_read(18'h00010, d, cyc);
        chk("rmid_valid_cleared", 32'(n_strb - s0), 32'd1);

        // random stress against a reference direct-mapped model
        lat = 2;
        pulse_reset();
        ref_v    = '0;
        errs     = 0;
        dut_hits = 0;
        ref_hits = 0;
        for (int i = 0; i < 10000; i++) begin
            a       = 18'h01000 + 18'($urandom_range(0, 255));
            idx     = a[5:0];
            ref_hit = ref_v[idx] && (ref_tag[idx] == a[17:6]);
            s0      = n_strb;
            do_read(a, d, cyc);
            if (ref_hit) ref_hits++;
            if (n_strb == s0) dut_hits++;
            if (d !== mw(a)) errs++;
            ref_v[idx]   = 1'b1;
            ref_tag[idx] = a[17:6];
        end
        chk("stress_data_errs", 32'(errs), 32'd0);
        chk("stress_hits", 32'(dut_hits), 32'(ref_hits));
        chk("stress_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
